// File: rtl/team_06_wb_sram_slave.sv
// Wishbone-classic slave SRAM with byte lanes, configurable wait states, abort and range checking.
// Define TEAM06_WB_SRAM_ERR_EN to answer out-of-range accesses with err_o instead of ack_o.
module team_06_wb_sram_slave #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH       = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h3300_0000,
  parameter int                WAIT_STATES = 1
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic [DATA_W/8-1:0]    wbs_sel_i,
  input  logic [ADDR_W-1:0]      wbs_adr_i,
  input  logic [DATA_W-1:0]      wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [DATA_W-1:0]      wbs_dat_o,
  output logic                   wbs_err_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int OFF_W = (SEL_W > 1) ? $clog2(SEL_W) : 0;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH * SEL_W);
  localparam logic [3:0] CNT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

`ifdef TEAM06_WB_SRAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]  adr_q, adr_d;
  logic               we_q, we_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0]  dat_q, dat_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  rdat_q, rdat_d;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic               commit;
  logic               c_we;
  logic [SEL_W-1:0]   c_sel;
  logic [ADDR_W-1:0]  c_adr;
  logic [DATA_W-1:0]  c_dat;
  logic [ADDR_W:0]    off;
  logic               in_rng;
  logic [IDX_W-1:0]   c_idx;
  logic               wr_en;

  // With zero wait states the commit edge is the request edge, so the
  // transfer fields come straight from the bus instead of the latches.
  always_comb begin
    c_adr  = (state_q == S_IDLE) ? wbs_adr_i : adr_q;
    c_we   = (state_q == S_IDLE) ? wbs_we_i  : we_q;
    c_sel  = (state_q == S_IDLE) ? wbs_sel_i : sel_q;
    c_dat  = (state_q == S_IDLE) ? wbs_dat_i : dat_q;
    off    = {1'b0, c_adr} - {1'b0, BASE_ADDR};
    in_rng = !off[ADDR_W] && (off < SPAN);
    c_idx  = off[OFF_W +: IDX_W];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    rdat_d  = rdat_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          adr_d = wbs_adr_i;
          we_d  = wbs_we_i;
          sel_d = wbs_sel_i;
          dat_d = wbs_dat_i;
          if (WAIT_STATES == 0) begin
            commit  = 1'b1;
            state_d = S_ACK;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!wbs_cyc_i) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (commit) rdat_d = (c_we || !in_rng) ? '0 : mem[c_idx];
    ack_d = commit && !(ERR_EN && !in_rng);
    err_d = commit && ERR_EN && !in_rng;
  end

  // nrst gate keeps a request held during reset from writing the array.
  assign wr_en = commit && c_we && in_rng && nrst;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (c_sel[b]) mem[c_idx][8*b +: 8] <= c_dat[8*b +: 8];
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign wbs_dat_o = rdat_q;

endmodule

// File: tb/tb_team_06_wb_sram_slave.sv
// Bench for team_06_wb_sram_slave: three instances (WAIT_STATES 1, 3, 0) checked
// against directed vectors, a word-array reference model and multi-cycle sequences.
module tb_team_06_wb_sram_slave;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h3300_0000;

  logic        clk = 1'b0;
  logic        nrst;
  logic        cyc [3];
  logic        stb [3];
  logic        we  [3];
  logic [3:0]  sel [3];
  logic [31:0] adr [3];
  logic [31:0] dati[3];
  logic        ack [3];
  logic [31:0] dato[3];
  logic        err [3];

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : gi
      team_06_wb_sram_slave #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE),
        .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 3 : 0))
      ) dut (
        .clk(clk), .nrst(nrst),
        .wbs_cyc_i(cyc[g]), .wbs_stb_i(stb[g]), .wbs_we_i(we[g]),
        .wbs_sel_i(sel[g]), .wbs_adr_i(adr[g]), .wbs_dat_i(dati[g]),
        .wbs_ack_o(ack[g]), .wbs_dat_o(dato[g]), .wbs_err_o(err[g])
      );
    end
  endgenerate

  int tests = 0;
  int fails = 0;
  logic [31:0] model [3][DEPTH];

  typedef struct {
    bit          w;
    logic [3:0]  s;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;
  vec_t tbl[16];

  function automatic int ws(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + DEPTH * 4);
  endfunction

  function automatic logic [31:0] ref_rd(input int k, input logic [31:0] a);
    if (!in_rng(a)) return 32'h0;
    return model[k][(a - BASE) / 4];
  endfunction

  task automatic ref_wr(input int k, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] w;
    int idx;
    if (in_rng(a)) begin
      idx = int'((a - BASE) / 4);
      w = model[k][idx];
      for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      model[k][idx] = w;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic xfer(input int k, input bit w, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rd, output int lat, output logic e);
    @(negedge clk);
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; sel[k] = s; adr[k] = a; dati[k] = d;
    lat = -1; rd = 32'h0; e = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ack[k] === 1'b1) begin
        lat = n; rd = dato[k]; e = err[k];
        break;
      end
    end
    cyc[k] = 1'b0; stb[k] = 1'b0;
  endtask

  task automatic do_vec(input int k, input bit w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input string name);
    logic [31:0] rd;
    int lat;
    logic e;
    xfer(k, w, s, a, d, rd, lat, e);
    check({name, " latency"}, lat, ws(k) + 1);
    check({name, " dat"}, rd, exp_rd);
    check({name, " err"}, {31'h0, e}, 32'h0);
    if (w) ref_wr(k, a, s, d);
  endtask

  task automatic watch_no_ack(input int k, input int n, input string name);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ack[k] !== 1'b0) seen++;
    end
    check(name, seen, 0);
  endtask

  initial begin
    logic [31:0] rd, a, d, old;
    logic [3:0]  s;
    bit          w;
    int          lat, nack, last, consec;
    logic        e, prev;
    logic [31:0] b2b_exp;

    nrst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc[k] = 0; stb[k] = 0; we[k] = 0; sel[k] = 0; adr[k] = 0; dati[k] = 0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst ack%0d", k), {31'h0, ack[k]}, 32'h0);
      check($sformatf("rst dat%0d", k), dato[k], 32'h0);
      check($sformatf("rst err%0d", k), {31'h0, err[k]}, 32'h0);
    end
    nrst = 1'b1;

    for (int k = 0; k < 3; k++)
      for (int i = 0; i < DEPTH; i++) begin
        d = $urandom;
        xfer(k, 1'b1, 4'hF, BASE + 32'(i * 4), d, rd, lat, e);
        ref_wr(k, BASE + 32'(i * 4), 4'hF, d);
      end

    tbl[0]  = '{1'b1, 4'hF, BASE + 8,   32'hDEAD_BEEF, 32'h0};
    tbl[1]  = '{1'b0, 4'hF, BASE + 8,   32'h0,         32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 4'hF, BASE + 12,  32'h1122_3344, 32'h0};
    tbl[3]  = '{1'b1, 4'h5, BASE + 12,  32'hAABB_CCDD, 32'h0};
    tbl[4]  = '{1'b0, 4'hF, BASE + 12,  32'h0,         32'h11BB_33DD};
    tbl[5]  = '{1'b1, 4'hF, BASE + 0,   32'hCAFE_F00D, 32'h0};
    tbl[6]  = '{1'b1, 4'hF, BASE + 256, 32'h1234_5678, 32'h0};
    tbl[7]  = '{1'b0, 4'hF, BASE + 0,   32'h0,         32'hCAFE_F00D};
    tbl[8]  = '{1'b0, 4'hF, BASE + 256, 32'h0,         32'h0};
    tbl[9]  = '{1'b0, 4'hF, BASE - 4,   32'h0,         32'h0};
    tbl[10] = '{1'b0, 4'hF, BASE + 9,   32'h0,         32'hDEAD_BEEF};
    tbl[11] = '{1'b1, 4'hF, BASE + 252, 32'h0102_0304, 32'h0};
    tbl[12] = '{1'b1, 4'hA, BASE + 252, 32'hF0E0_D0C0, 32'h0};
    tbl[13] = '{1'b0, 4'hF, BASE + 252, 32'h0,         32'hF002_D004};
    tbl[14] = '{1'b1, 4'h0, BASE + 8,   32'h0000_0000, 32'h0};
    tbl[15] = '{1'b0, 4'hF, BASE + 8,   32'h0,         32'hDEAD_BEEF};
    for (int i = 0; i < 16; i++)
      do_vec(0, tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].e, $sformatf("vec%0d", i));

    for (int i = 0; i < 200; i++) begin
      int k = i % 2;
      if ($urandom_range(0, 9) == 0)
        a = ($urandom_range(0, 1) == 0) ? BASE - 32'($urandom_range(1, 64))
                                        : BASE + DEPTH * 4 + 32'($urandom_range(0, 64));
      else
        a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      s = 4'($urandom_range(0, 15));
      d = $urandom;
      do_vec(k, w, s, a, d, w ? 32'h0 : ref_rd(k, a), $sformatf("rnd%0d", i));
    end

    // Abort: cyc dropped after one wait cycle of a 3-wait-state write.
    old = ref_rd(1, BASE + 16);
    @(negedge clk);
    cyc[1] = 1; stb[1] = 1; we[1] = 1; sel[1] = 4'hF; adr[1] = BASE + 16; dati[1] = 32'h5555_5555;
    @(negedge clk);
    @(negedge clk);
    cyc[1] = 0; stb[1] = 0;
    watch_no_ack(1, 8, "abort no ack");
    do_vec(1, 1'b0, 4'hF, BASE + 16, 32'h0, old, "abort readback");

    // Reset asserted while a write sits in WAIT.
    do_vec(1, 1'b1, 4'hF, BASE + 0, 32'h0BAD_F00D, 32'h0, "pre-rst wr");
    do_vec(1, 1'b0, 4'hF, BASE + 0, 32'h0, 32'h0BAD_F00D, "pre-rst rd");
    old = ref_rd(1, BASE + 20);
    @(negedge clk);
    cyc[1] = 1; stb[1] = 1; we[1] = 1; sel[1] = 4'hF; adr[1] = BASE + 20; dati[1] = 32'hA5A5_A5A5;
    @(negedge clk);
    nrst = 1'b0;
    #1;
    check("mid-rst ack", {31'h0, ack[1]}, 32'h0);
    check("mid-rst dat", dato[1], 32'h0);
    @(negedge clk);
    cyc[1] = 0; stb[1] = 0;
    nrst = 1'b1;
    watch_no_ack(1, 6, "post-rst no ack");
    do_vec(1, 1'b0, 4'hF, BASE + 20, 32'h0, old, "post-rst readback");
    do_vec(1, 1'b0, 4'hF, BASE + 0, 32'h0, 32'h0BAD_F00D, "committed kept");

    // Back-to-back reads with cyc&stb held, zero wait states.
    @(negedge clk);
    cyc[2] = 1; stb[2] = 1; we[2] = 0; sel[2] = 4'hF; adr[2] = BASE + 4;
    nack = 0; last = 0; consec = 0; prev = 1'b0; b2b_exp = 32'h0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (ack[2] === 1'b1) begin
        if (prev) consec++;
        b2b_exp = ref_rd(2, BASE + 32'(4 * (nack + 1)));
        check($sformatf("b2b dat%0d", nack), dato[2], b2b_exp);
        check($sformatf("b2b gap%0d", nack), n - last, (nack == 0) ? 1 : 2);
        last = n;
        nack++;
        adr[2] = BASE + 32'(4 * (nack + 1));
        if (nack == 3) break;
      end
      prev = ack[2];
    end
    cyc[2] = 0; stb[2] = 0;
    check("b2b count", nack, 3);
    @(negedge clk);
    check("b2b ack drop", {31'h0, ack[2]}, 32'h0);
    check("b2b consec", consec, 0);
    @(negedge clk);
    check("dat hold", dato[2], b2b_exp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
